// File: rtl/pseudo_softmax_pkg.sv
// Shared constants, FSM encoding and width helpers for the pseudo-softmax family.
package pseudo_softmax_pkg;

    localparam int DEF_N  = 10;
    localparam int DEF_W  = 8;
    localparam int DEF_F  = 8;
    localparam int DEF_EW = 8;
    localparam int DEF_MW = 8;

    typedef enum logic [1:0] {
        ST_LOAD = 2'd0,
        ST_SUM  = 2'd1,
        ST_NORM = 2'd2,
        ST_OUT  = 2'd3
    } state_e;

    // Ceiling log2; clog2(1) = 0.
    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

    // Sum of N terms each <= 1.0 in F fraction bits, plus one bit of margin.
    function automatic int acc_width(input int f, input int n);
        return f + clog2(n) + 1;
    endfunction

endpackage

// File: rtl/pseudo_softmax_stream_lead_one_norm.sv
// Leading-one normaliser: acc = 2^(F+k) * (1 + mant/2^MW), mant truncated.
module lead_one_norm
    import pseudo_softmax_pkg::*;
#(
    parameter int AW = 13,
    parameter int F  = 8,
    parameter int MW = 8,
    parameter int KW = 3
) (
    input  logic [AW-1:0] acc_i,
    output logic [KW-1:0] k_o,
    output logic [MW-1:0] mant_o
);

    localparam int PW = clog2(AW);

    logic [PW-1:0]      pos;
    logic [AW-1:0]      aligned;
    logic [AW+MW-2:0]   ext;

    // Find the leading one, shift it to the top, take the MW bits below it.
    always_comb begin
        pos = '0;
        for (int i = 0; i < AW; i++) begin
            if (acc_i[i]) pos = PW'(i);
        end
        aligned = acc_i << (PW'(AW - 1) - pos);
        // Zero-fill below the real bits covers the case of fewer than MW bits.
        ext     = {aligned[AW-2:0], {MW{1'b0}}};
        mant_o  = ext[AW+MW-2 -: MW];
        k_o     = (pos >= PW'(F)) ? KW'(pos - PW'(F)) : '0;
    end

endmodule

// File: rtl/pseudo_softmax_stream.sv
// Streaming base-2 pseudo-softmax: load N logits, sum 2^-d terms, normalise, emit.
module pseudo_softmax_stream
    import pseudo_softmax_pkg::*;
#(
    parameter int N  = DEF_N,
    parameter int W  = DEF_W,
    parameter int F  = DEF_F,
    parameter int EW = DEF_EW,
    parameter int MW = DEF_MW
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [W-1:0]        in_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [EW-1:0]       out_exp,
    output logic [MW-1:0]       out_mant,
    output logic [clog2(N)-1:0] out_idx,
    output logic                out_last,
    output logic                busy
);

    localparam int CW  = clog2(N);
    localparam int AW  = acc_width(F, N);
    localparam int KW  = clog2(CW + 1);
    localparam int WE  = (W > EW) ? W : EW;
    localparam int SW  = ((WE > KW) ? WE : KW) + 1;
    localparam logic [SW-1:0] EMAX   = SW'((64'd1 << EW) - 64'd1);
    localparam logic [CW-1:0] LAST_I = CW'(N - 1);

    state_e          state_q, state_d;

    logic [W-1:0]    buf_q [N];
    logic [W-1:0]    d_q   [N];
    logic [W-1:0]    max_q;
    logic [AW-1:0]   acc_q;
    logic [KW-1:0]   k_q;
    logic [MW-1:0]   mant_q;
    logic [CW-1:0]   ptr_q;      // load count, sum index and issue index by phase
    logic            iss_done_q;
    logic            in_ready_q;
    logic            ov_q;
    logic [EW-1:0]   oexp_q;
    logic [CW-1:0]   oidx_q;
    logic            olast_q;

    logic            in_hs, out_hs, issue, ptr_last;
    logic [W-1:0]    d_cur;
    logic [AW-1:0]   term;
    logic [SW-1:0]   e_full;
    logic [EW-1:0]   e_sat;
    logic [KW-1:0]   k_n;
    logic [MW-1:0]   mant_n;

    assign in_ready  = in_ready_q;
    assign out_valid = ov_q;
    assign out_exp   = oexp_q;
    assign out_mant  = mant_q;
    assign out_idx   = oidx_q;
    assign out_last  = olast_q;
    assign busy      = !(state_q == ST_LOAD && ptr_q == '0);

    assign in_hs    = in_valid & in_ready_q;
    assign out_hs   = ov_q & out_ready;
    assign ptr_last = (ptr_q == LAST_I);
    // Output register refills whenever it is empty or draining this cycle.
    assign issue    = (state_q == ST_OUT) && !iss_done_q && (!ov_q || out_ready);

    lead_one_norm #(.AW(AW), .F(F), .MW(MW), .KW(KW)) u_norm (
        .acc_i  (acc_q),
        .k_o    (k_n),
        .mant_o (mant_n)
    );

    // Per-element distance from the max, its 2^-d term, and the saturated exponent.
    always_comb begin
        d_cur  = max_q - buf_q[ptr_q];
        term   = '0;
        if (32'(d_cur) <= F) term = (AW'(1) << F) >> d_cur;
        e_full = SW'(d_q[ptr_q]) + SW'(k_q);
        e_sat  = (e_full > EMAX) ? {EW{1'b1}} : e_full[EW-1:0];
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= ST_LOAD;
        else        state_q <= state_d;
    end

    // Next-state logic; vectors never overlap.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_LOAD: if (in_hs && ptr_last) state_d = ST_SUM;
            ST_SUM:  if (ptr_last)          state_d = ST_NORM;
            ST_NORM:                        state_d = ST_OUT;
            ST_OUT:  if (out_hs && olast_q) state_d = ST_LOAD;
            default:                        state_d = ST_LOAD;
        endcase
    end

    // Datapath: buffer, running max, accumulation, normalisation and output beats.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < N; i++) begin
                buf_q[i] <= '0;
                d_q[i]   <= '0;
            end
            max_q      <= '0;
            acc_q      <= '0;
            k_q        <= '0;
            mant_q     <= '0;
            ptr_q      <= '0;
            iss_done_q <= 1'b0;
            in_ready_q <= 1'b0;
            ov_q       <= 1'b0;
            oexp_q     <= '0;
            oidx_q     <= '0;
            olast_q    <= 1'b0;
        end else begin
            in_ready_q <= (state_d == ST_LOAD);
            case (state_q)
                ST_LOAD: begin
                    if (in_hs) begin
                        buf_q[ptr_q] <= in_data;
                        if (ptr_q == '0 || in_data > max_q) max_q <= in_data;
                        ptr_q <= ptr_last ? '0 : ptr_q + CW'(1);
                        acc_q <= '0;
                    end
                end
                ST_SUM: begin
                    d_q[ptr_q] <= d_cur;
                    acc_q      <= acc_q + term;
                    ptr_q      <= ptr_last ? '0 : ptr_q + CW'(1);
                end
                ST_NORM: begin
                    k_q        <= k_n;
                    mant_q     <= mant_n;
                    ptr_q      <= '0;
                    iss_done_q <= 1'b0;
                end
                ST_OUT: begin
                    if (issue) begin
                        ov_q       <= 1'b1;
                        oexp_q     <= e_sat;
                        oidx_q     <= ptr_q;
                        olast_q    <= ptr_last;
                        iss_done_q <= ptr_last;
                        if (!ptr_last) ptr_q <= ptr_q + CW'(1);
                    end else if (out_hs) begin
                        ov_q <= 1'b0;
                        if (olast_q) begin
                            olast_q <= 1'b0;
                            oidx_q  <= '0;
                            ptr_q   <= '0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/pseudo_softmax_stream.md
Name: pseudo_softmax_stream

Overview:
- Parametrised, streaming successor to the fixed 10-input pseudo-softmax.
- Accepts one vector of N unsigned W-bit logits, one element per valid/ready handshake, and computes a base-2 pseudo-softmax.
- Emits N results in input order as a per-element exponent plus a shared mantissa: p_i = 2^-exp_i / (1 + mant/2^MW).
- Sits between the classifier output layer and the decision/argmax logic.

Parameters:
- N, 10, elements per vector (>=2).
- W, 8, input logit width, unsigned.
- F, 8, fraction bits of the internal 2^-d terms and sum.
- EW, 8, output exponent width; saturating.
- MW, 8, output mantissa width.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous active-low reset.
- in_valid  in  1  in_data is valid.
- in_ready  out  1  block accepts in_data this cycle.
- in_data  in  W  unsigned logit.
- out_valid  out  1  output beat is valid.
- out_ready  in  1  downstream accepts the output beat.
- out_exp  out  EW  exp_i for the current element.
- out_mant  out  MW  shared normalised mantissa for the vector.
- out_idx  out  clog2(N)  element index, 0..N-1.
- out_last  out  1  high on the beat with out_idx == N-1.
- busy  out  1  high in every state except LOAD with 0 elements held.

Behaviour:
- Reset: clock and reset are a single clk with synchronous, active-low rst_n, sampled on the rising edge. While rst_n=0, all state registers clear and the state goes to LOAD with count 0. Reset values: in_ready=0, out_valid=0, out_exp=0, out_mant=0, out_idx=0, out_last=0, busy=0. in_ready asserts the first cycle after rst_n returns high.
- Reset mid-operation: in any state, the partial vector, sum and outputs are discarded with no further beats. The next accepted element is element 0.
- FSM states: LOAD, SUM, NORM, OUT.
- LOAD:
  - in_ready=1.
  - Each handshake (in_valid & in_ready) stores in_data into buf[count] and updates run_max = max(run_max, in_data). The first element loads run_max directly.
  - On the handshake with count == N-1, go to SUM and drop in_ready the next cycle.
- SUM:
  - Exactly N cycles, one element per cycle, index j = 0..N-1.
  - d_j = run_max - buf[j]. This never underflows because max >= x.
  - Store d_j.
  - term_j = (1<<F) >> d_j; the term is 0 when d_j > F.
  - acc += term_j.
  - acc width is F + clog2(N) + 1 and cannot overflow.
- NORM: 1 cycle.
  - acc >= 2^F always, because the max element contributes 1.0.
  - k = msb_pos(acc) - F, range 0..clog2(N).
  - mant = the MW bits immediately below the leading one of acc, truncated, with zero-fill if too few bits.
  - Go to OUT.
- OUT:
  - out_valid=1.
  - out_exp = min(d_idx + k, 2^EW - 1).
  - out_mant is held constant for the whole vector.
  - Outputs hold stable while out_valid & !out_ready.
  - Handshake advances out_idx.
  - On the out_last handshake, return to LOAD with count=0; in_ready=1 the next cycle.
- No overlap between vectors: in_ready=0 in SUM, NORM and OUT.
- Latency: from the last input handshake to the first out_valid is N+2 cycles (N SUM, 1 NORM, 1 register). Throughput is one beat per cycle when out_ready=1.
- Ties: equal maxima each give d=0. Order of arrival is irrelevant.

Decomposition:
- Shared package/header pseudo_softmax_pkg:
  - FSM state encodings (LOAD, SUM, NORM, OUT).
  - clog2 constant function.
  - Default parameter values.
  - The accumulator-width expression.
- One sub-module, lead_one_norm: a combinational leading-one detector over acc that returns k and the MW-bit mantissa. It is reused by future softmax variants.
- Buffers, counters and the FSM stay in the top module.

Test Plan:
- Defaults, all ten inputs 0x20, out_ready=1 -> acc=10.0; ten beats with out_exp=3, out_mant=64 (p=0.1 each); out_last on idx 9; first out_valid 12 cycles after the last input handshake.
- Defaults, inputs 01,03,05,07,11,33,02,25,12,06 -> sum truncates to 1.0, k=0, mant=0; out_exp = 50,48,46,44,34,0,49,14,33,45.
- Defaults, inputs 10,9, then eight 0s -> acc=1.5, k=0, mant=128; out_exp = 0,1,10,10,10,10,10,10,10,10.
- EW=4, inputs 0xFF then nine 0x00 -> d=255 for elements 1..9; out_exp saturates to 15 for those and is 0 for element 0; mant=0.
- Backpressure: random in_valid gaps and out_ready low for 3 cycles mid-vector -> outputs hold stable while stalled; no beat lost or duplicated; in_ready stays 0 until after the out_last handshake.
- Reset mid-vector: rst_n=0 for 1 cycle after 5 inputs, then a full fresh vector -> results match the fresh vector only; out_valid stays 0 during and after reset until the new vector completes.
